// File: rtl/dac_spi_pkg.sv
// Shared constants and types for the LTC2624 DAC frame responder.
package dac_spi_pkg;

    localparam int FRAME_BITS_DEF = 32;
    localparam int CMD_W          = 4;
    localparam int ADDR_W         = 4;
    localparam int DATOS_W        = 12;

    // Field positions inside the 32-bit frame, bit 31 sent first
    localparam int CMD_LSB   = 20;
    localparam int ADDR_LSB  = 16;
    localparam int DATOS_LSB = 4;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_NOP          = 4'b1111;
    localparam logic [3:0] ADDR_A           = 4'h0;
    localparam logic [3:0] ADDR_B           = 4'h1;
    localparam logic [3:0] ADDR_C           = 4'h2;
    localparam logic [3:0] ADDR_D           = 4'h3;
    localparam logic [3:0] ADDR_ALL         = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/dac_spi_responder_if.sv
// DAC SPI bus plus decoded-frame outputs; master = bus driver, slave = responder.
interface dac_spi_responder_if;
    import dac_spi_pkg::*;

    logic                 spi_sck;
    logic                 spi_mosi;
    logic                 dac_cs;
    logic                 dac_clr;
    logic                 spi_miso;
    logic [CMD_W-1:0]     cmd;
    logic [ADDR_W-1:0]    addr;
    logic [DATOS_W-1:0]   datos;
    logic                 frame_valid;
    logic                 frame_error;

    modport master (
        output spi_sck, spi_mosi, dac_cs, dac_clr,
        input  spi_miso, cmd, addr, datos, frame_valid, frame_error
    );

    modport slave (
        input  spi_sck, spi_mosi, dac_cs, dac_clr,
        output spi_miso, cmd, addr, datos, frame_valid, frame_error
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous bus input, with a history flop
// giving single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clock) begin
                    if (reset) r_sync[gi] <= RST_VAL;
                    else       r_sync[gi] <= i_async;
                end
            end else begin : g_next
                always_ff @(posedge clock) begin
                    if (reset) r_sync[gi] <= RST_VAL;
                    else       r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) r_hist <= RST_VAL;
        else       r_hist <= r_sync[SYNC_STAGES-1];
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_hist;
    assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/dac_spi_responder.sv
// Oversampling SPI responder decoding LTC2624 32-bit frames into cmd/addr/datos.
// Optional SDO echo of the previous accepted frame: define DAC_SDO_ECHO_EN.
module dac_spi_responder
    import dac_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    dac_spi_responder_if.slave         bus
);

    logic w_sck_level, w_sck_rise, w_sck_fall;
    logic w_cs_level,  w_cs_rise,  w_cs_fall;
    logic w_clr_level, w_clr_rise, w_clr_fall;
    logic w_mosi_level, w_mosi_rise, w_mosi_fall;

    // CS and CLR idle high, so their synchronisers reset high to avoid a phantom edge
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clock(clock), .reset(reset), .i_async(bus.spi_sck),
        .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .i_async(bus.dac_cs),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clr (
        .clock(clock), .reset(reset), .i_async(bus.dac_clr),
        .o_level(w_clr_level), .o_rise(w_clr_rise), .o_fall(w_clr_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .i_async(bus.spi_mosi),
        .o_level(w_mosi_level), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

    state_t              r_state;
    logic [5:0]          r_count;
    logic [31:0]         r_shift;
    logic                r_fall_pend;
    logic [CMD_W-1:0]    r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATOS_W-1:0]  r_datos;
    logic                r_valid;
    logic                r_error;

    // Bit and count as they stand after this cycle's SCK edge, so a final edge
    // coinciding with CS rise is included in the frame check.
    logic [31:0] w_data_eff;
    logic [5:0]  w_count_eff;
    logic        w_accept;

    assign w_data_eff  = w_sck_rise ? {r_shift[30:0], w_mosi_level} : r_shift;
    assign w_count_eff = (w_sck_rise && r_count != 6'd63) ? r_count + 6'd1 : r_count;
    assign w_accept    = w_clr_level && (r_state == SHIFT) && w_cs_rise &&
                         (w_count_eff == 6'(FRAME_BITS));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_fall_pend <= 1'b0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_datos     <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (!w_clr_level) begin
                r_cmd       <= '0;
                r_addr      <= '0;
                r_datos     <= '0;
                r_state     <= IDLE;
                r_count     <= '0;
                r_fall_pend <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall || r_fall_pend) begin
                            r_state     <= SHIFT;
                            r_count     <= '0;
                            r_fall_pend <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (w_sck_rise) begin
                            r_shift <= w_data_eff;
                            r_count <= w_count_eff;
                        end
                        if (w_cs_rise) begin
                            r_state <= LATCH;
                            if (w_accept) begin
                                r_cmd   <= w_data_eff[CMD_LSB +: CMD_W];
                                r_addr  <= w_data_eff[ADDR_LSB +: ADDR_W];
                                r_datos <= w_data_eff[DATOS_LSB +: DATOS_W];
                                r_valid <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    LATCH: begin
                        // A CS fall here starts the next frame from IDLE one cycle later
                        r_state     <= IDLE;
                        r_fall_pend <= w_cs_fall;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cmd         = r_cmd;
    assign bus.addr        = r_addr;
    assign bus.datos       = r_datos;
    assign bus.frame_valid = r_valid;
    assign bus.frame_error = r_error;

    logic w_unused;

`ifdef DAC_SDO_ECHO_EN
    logic [31:0] r_echo;

    always_ff @(posedge clock) begin
        if (reset)
            r_echo <= '0;
        else if (w_accept)
            r_echo <= w_data_eff;
        else if (w_sck_fall && !w_cs_level)
            r_echo <= {r_echo[30:0], 1'b0};
    end

    assign bus.spi_miso = r_echo[31];
    assign w_unused     = ^{w_sck_level, w_mosi_rise, w_mosi_fall, w_clr_rise, w_clr_fall};
`else
    assign bus.spi_miso = 1'b0;
    assign w_unused     = ^{w_sck_level, w_sck_fall, w_cs_level, w_mosi_rise, w_mosi_fall,
                            w_clr_rise, w_clr_fall, w_data_eff[31:24], w_data_eff[3:0]};
`endif

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed bench for dac_spi_responder: drives SPI frames bit by bit and checks decode.
module tb_dac_spi_responder;
    import dac_spi_pkg::*;

    localparam int H = 5;   // SCK half period in system clocks

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dac_spi_responder_if bus();

    dac_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0;
    int          n_err = 0;
    logic [19:0] vq[$];
    logic [31:0] miso_word = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.frame_valid) begin
                n_valid++;
                vq.push_back({bus.cmd, bus.addr, bus.datos});
            end
            if (bus.frame_error) n_err++;
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Sends data[nbits-1:0] MSB first; dac_clr pulled low at bit clr_at for 3 bits.
    task automatic send(input logic [63:0] data, input int nbits, input int clr_at, input int gap);
        bus.dac_cs = 1'b0;
        clocks(H);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.spi_mosi = data[i];
            if (i == clr_at)     bus.dac_clr = 1'b0;
            if (i == clr_at - 3) bus.dac_clr = 1'b1;
            clocks(H);
            miso_word   = {miso_word[30:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            clocks(H);
            bus.spi_sck = 1'b0;
        end
        clocks(H);
        bus.dac_cs = 1'b1;
        clocks(gap);
        $display("frame %h bits %0d: valid_total=%0d error_total=%0d cmd=%h addr=%h datos=%h",
                 data, nbits, n_valid, n_err, bus.cmd, bus.addr, bus.datos);
    endtask

    logic [19:0] ent;
    int          v0, e0;
    logic [31:0] exp_echo;

    initial begin
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.dac_cs   = 1'b1;
        bus.dac_clr  = 1'b1;
        clocks(5);
        reset = 1'b0;
        clocks(5);

        chk("rst_cmd",   32'(bus.cmd),         32'h0);
        chk("rst_addr",  32'(bus.addr),        32'h0);
        chk("rst_datos", 32'(bus.datos),       32'h0);
        chk("rst_valid", 32'(bus.frame_valid), 32'h0);
        chk("rst_error", 32'(bus.frame_error), 32'h0);
        chk("rst_miso",  32'(bus.spi_miso),    32'h0);

        // Well-formed 32-bit frame
        v0 = n_valid; e0 = n_err;
        send(64'h0030_ABC0, 32, -1, 10);
        chk("f1_nvalid", 32'(n_valid - v0), 32'd1);
        chk("f1_nerr",   32'(n_err - e0),   32'd0);
        chk("f1_cmd",    32'(bus.cmd),      32'(CMD_WRITE_UPDATE));
        chk("f1_addr",   32'(bus.addr),     32'(ADDR_A));
        chk("f1_datos",  32'(bus.datos),    32'h0ABC);

        // Short frame: rejected, outputs hold
        v0 = n_valid; e0 = n_err;
        send(64'h0051_2340 >> 1, 31, -1, 10);
        chk("short_nerr",   32'(n_err - e0),   32'd1);
        chk("short_nvalid", 32'(n_valid - v0), 32'd0);
        chk("short_cmd",    32'(bus.cmd),      32'h3);
        chk("short_datos",  32'(bus.datos),    32'h0ABC);

        // Long frame, then a good one
        v0 = n_valid; e0 = n_err;
        send(64'h1_0030_1230, 33, -1, 10);
        chk("long_nerr",   32'(n_err - e0),   32'd1);
        chk("long_nvalid", 32'(n_valid - v0), 32'd0);
        v0 = n_valid; e0 = n_err;
        send(64'h003F_FFF0, 32, -1, 10);
        chk("ff_nvalid", 32'(n_valid - v0), 32'd1);
        chk("ff_nerr",   32'(n_err - e0),   32'd0);
        chk("ff_datos",  32'(bus.datos),    32'h0FFF);
        chk("ff_addr",   32'(bus.addr),     32'(ADDR_ALL));

        // dac_clr mid-frame: cleared outputs, no pulse
        v0 = n_valid; e0 = n_err;
        send(64'h0031_2340, 32, 20, 10);
        chk("clr_nvalid", 32'(n_valid - v0), 32'd0);
        chk("clr_nerr",   32'(n_err - e0),   32'd0);
        chk("clr_datos",  32'(bus.datos),    32'h0);
        chk("clr_cmd",    32'(bus.cmd),      32'h0);
        chk("clr_addr",   32'(bus.addr),     32'h0);
        send(64'h0031_5550, 32, -1, 10);
        chk("postclr_datos", 32'(bus.datos), 32'h0555);
        chk("postclr_addr",  32'(bus.addr),  32'(ADDR_B));
        chk("postclr_cmd",   32'(bus.cmd),   32'h3);

        // Back-to-back frames with a one-clock CS-high gap
        v0 = n_valid; e0 = n_err;
        vq.delete();
        send(64'h0031_1110, 32, -1, 1);
        send(64'h0032_2220, 32, -1, 10);
        chk("b2b_nvalid", 32'(n_valid - v0), 32'd2);
        chk("b2b_nerr",   32'(n_err - e0),   32'd0);
        chk("b2b_qsize",  32'(vq.size()),    32'd2);
        if (vq.size() == 2) begin
            ent = vq[0];
            chk("b2b_addr0",  32'(ent[15:12]), 32'(ADDR_B));
            chk("b2b_datos0", 32'(ent[11:0]),  32'h0111);
            ent = vq[1];
            chk("b2b_addr1",  32'(ent[15:12]), 32'(ADDR_C));
            chk("b2b_datos1", 32'(ent[11:0]),  32'h0222);
        end

        // Echo: MISO during the second frame replays the first accepted frame
        send(64'h0031_2340, 32, -1, 10);
        miso_word = '0;
        send(64'h0030_0000, 32, -1, 10);
`ifdef DAC_SDO_ECHO_EN
        exp_echo = 32'h0031_2340;
`else
        exp_echo = 32'h0;
`endif
        chk("echo_word",  miso_word,        exp_echo);
        chk("echo_datos", 32'(bus.datos),   32'h0);
        chk("echo_addr",  32'(bus.addr),    32'(ADDR_A));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
